tile_scheduler: RTL and testbench
=================================

TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 SHALL have clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have start  in  1  one-cycle pulse; launches a layer when idle.
REQ-004 SHALL have num_tiles_m, num_tiles_n, num_tiles_k  in  8 each  tile counts for rows of A, columns of B, and the shared dimension.
REQ-005 SHALL have start_mat_mul  out  1  level request to the 4x4 matmul.
REQ-006 SHALL have done_mat_mul  in  1  pulse from the matmul when the current tile product is complete.
REQ-007 SHALL have a_loc, b_loc  out  8 each  tile locations passed to the matmul.
REQ-008 SHALL have first_k, last_k  out  1 each  accumulation-boundary flags valid while start_mat_mul=1.
REQ-009 SHALL have wb_done  in  1  pulse from the output-BRAM writer when the output tile has been written.
REQ-010 SHALL have busy  out  1; done_all  out  1 (one-cycle pulse); cfg_err  out  1; err_timeout  out  1.

Function
REQ-011 SHALL latch num_tiles_* on an accepted start; later input changes SHALL have no effect until the next start.
REQ-012 SHALL implement FSM states IDLE, RUN_MM, STEP, WAIT_WB, DONE, ERR.
REQ-013 IDLE + start SHALL go to RUN_MM next cycle with m=n=k=0; start while not IDLE SHALL be ignored.
REQ-014 start_mat_mul SHALL be 1 exactly in RUN_MM; done_mat_mul sampled in RUN_MM SHALL move to STEP.
REQ-015 done_mat_mul outside RUN_MM and wb_done outside WAIT_WB SHALL be ignored.
REQ-016 Loop order SHALL be m outer, n middle, k inner.
REQ-017 a_loc SHALL equal (m*num_tiles_k + k) mod 256.
REQ-018 b_loc SHALL equal (k*num_tiles_n + n) mod 256.
REQ-019 first_k SHALL be (k==0); last_k SHALL be (k==num_tiles_k-1).
REQ-020 STEP SHALL last one cycle with start_mat_mul=0. If k<num_tiles_k-1: k++ and go to RUN_MM. Otherwise k=0 and go to WAIT_WB.
REQ-021 WAIT_WB + wb_done SHALL advance n, wrapping to 0 with m++.
REQ-022 From WAIT_WB, the FSM SHALL return to RUN_MM, or go to DONE when the tile was (num_tiles_m-1, num_tiles_n-1).
REQ-023 DONE SHALL pulse done_all for one cycle and return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 If any latched count is 0, start SHALL go directly to DONE with no start_mat_mul and SHALL set cfg_err.
REQ-026 cfg_err SHALL hold until the next accepted start, then clear.
REQ-027 Index counters SHALL be 8-bit; location products SHALL be computed at 16 bits and truncated to 8 bits.

Reset
REQ-028 reset=0 SHALL force IDLE immediately; start_mat_mul, done_all, busy, first_k, last_k, cfg_err, err_timeout SHALL be 0; a_loc, b_loc and counters SHALL be 0.
REQ-029 Reset asserted mid-layer SHALL abandon the layer; no done_all SHALL follow reset release.

Configuration
REQ-030 With TILE_SCHED_TIMEOUT_EN defined, an 8-bit watchdog SHALL count cycles in RUN_MM and clear on entry to RUN_MM.
REQ-031 With TILE_SCHED_TIMEOUT_EN defined, a count reaching 255 without done_mat_mul SHALL drop start_mat_mul and go to ERR.
REQ-032 In ERR, err_timeout SHALL be 1, busy SHALL be 1, and the FSM SHALL stay until reset; no done_all SHALL be produced.
REQ-033 Without TILE_SCHED_TIMEOUT_EN, no watchdog logic SHALL exist, err_timeout SHALL be tied 0, and ERR SHALL be unreachable.

Structure
REQ-034 FSM state encodings, the watchdog limit (255) and the index width (8) SHALL live in the shared package/defines file alongside `DWIDTH/`AWIDTH.
REQ-035 The m/n/k nested counter SHALL be one sub-module, tile_index_counter, with step/clear inputs and wrap flags; the FSM SHALL remain in tile_scheduler.

Verification
REQ-036 m=n=k=1, start; matmul answers 3 cycles after request, wb_done 2 cycles after STEP -> exactly one start_mat_mul burst, a_loc=b_loc=0, first_k=last_k=1, done_all one pulse.
REQ-037 m=2,n=2,k=3 -> 12 matmul requests, 4 wb_done waits; a_loc sequence 0,1,2,0,1,2,3,4,5,3,4,5; b_loc sequence 0,2,4,1,3,5,0,2,4,1,3,5.
REQ-038 k=0, start -> no start_mat_mul, cfg_err=1, done_all pulse; a following valid start clears cfg_err.
REQ-039 start pulsed during RUN_MM, stray done_mat_mul during WAIT_WB, and stray wb_done during RUN_MM -> sequence and counts unchanged.
REQ-040 reset=0 asserted in WAIT_WB of tile 1 -> all outputs 0 asynchronously; after release with no start, no done_all.
REQ-041 With TILE_SCHED_TIMEOUT_EN, done_mat_mul withheld -> start_mat_mul drops after 255 cycles, err_timeout=1 until reset; without the macro -> waits indefinitely and err_timeout=0.

Source files
------------

// File: rtl/tile_scheduler_pkg.sv
// Shared types and constants for the tile scheduler: FSM encoding, index width, watchdog limit.
// No logic state here; tile_loc() is the truncating 16-bit location product used by the top.
package tile_scheduler_pkg;

  localparam int DWIDTH     = 32;
  localparam int AWIDTH     = 8;
  localparam int IDX_W      = 8;
  localparam int WDOG_W     = 8;
  localparam int WDOG_LIMIT = 255;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN_MM  = 3'd1,
    ST_STEP    = 3'd2,
    ST_WAIT_WB = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  function automatic idx_t tile_loc(input idx_t outer, input idx_t stride, input idx_t inner);
    logic [15:0] w_prod;
    w_prod = 16'(outer) * 16'(stride) + 16'(inner);
    return w_prod[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/tile_scheduler_if.sv
// Control/handshake bundle between the tile scheduler (master) and its matmul/writeback environment (slave).
// Pure wiring; no latency, no backpressure beyond the level request / done pulses it carries.
interface tile_scheduler_if;
  import tile_scheduler_pkg::*;

  logic start;
  idx_t num_tiles_m;
  idx_t num_tiles_n;
  idx_t num_tiles_k;
  logic start_mat_mul;
  logic done_mat_mul;
  idx_t a_loc;
  idx_t b_loc;
  logic first_k;
  logic last_k;
  logic wb_done;
  logic busy;
  logic done_all;
  logic cfg_err;
  logic err_timeout;

  modport master (
    input  start, num_tiles_m, num_tiles_n, num_tiles_k, done_mat_mul, wb_done,
    output start_mat_mul, a_loc, b_loc, first_k, last_k, busy, done_all, cfg_err, err_timeout
  );

  modport slave (
    output start, num_tiles_m, num_tiles_n, num_tiles_k, done_mat_mul, wb_done,
    input  start_mat_mul, a_loc, b_loc, first_k, last_k, busy, done_all, cfg_err, err_timeout
  );

endinterface

// File: rtl/tile_scheduler_index_counter.sv
// Nested m/n/k tile index counter: k steps alone, n steps carry into m; wrap flags mark last indices.
// Updates one cycle after step/clear; clear dominates.
module tile_index_counter
  import tile_scheduler_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_step_k,
  input  logic i_step_n,
  input  idx_t i_cnt_m,
  input  idx_t i_cnt_n,
  input  idx_t i_cnt_k,
  output idx_t o_m,
  output idx_t o_n,
  output idx_t o_k,
  output logic o_m_wrap,
  output logic o_n_wrap,
  output logic o_k_wrap
);

  idx_t r_m, r_n, r_k;

  assign o_m      = r_m;
  assign o_n      = r_n;
  assign o_k      = r_k;
  assign o_m_wrap = (r_m == idx_t'(i_cnt_m - 8'd1));
  assign o_n_wrap = (r_n == idx_t'(i_cnt_n - 8'd1));
  assign o_k_wrap = (r_k == idx_t'(i_cnt_k - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m <= '0;
      r_n <= '0;
      r_k <= '0;
    end else if (i_clear) begin
      r_m <= '0;
      r_n <= '0;
      r_k <= '0;
    end else begin
      if (i_step_k) begin
        r_k <= o_k_wrap ? '0 : r_k + 8'd1;
      end
      if (i_step_n) begin
        if (o_n_wrap) begin
          r_n <= '0;
          r_m <= r_m + 8'd1;
        end else begin
          r_n <= r_n + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Walks m/n/k tiles for a matmul layer; request held in RUN_MM until done_mat_mul, one WAIT_WB per output tile.
// Optional RUN_MM watchdog under `TILE_SCHED_TIMEOUT_EN (lockup into ERR until reset).
module tile_scheduler
  import tile_scheduler_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  tile_scheduler_if.master bus
);

  state_t r_state, w_next;
  idx_t   r_nm, r_nn, r_nk;
  logic   r_cfg_err;
  logic   w_accept, w_zero;
  logic   w_clear, w_step_k, w_step_n;
  idx_t   w_m, w_n, w_k;
  logic   w_m_wrap, w_n_wrap, w_k_wrap;
  logic   w_timeout;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_zero   = (bus.num_tiles_m == '0) || (bus.num_tiles_n == '0) || (bus.num_tiles_k == '0);

  tile_index_counter u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_step_k (w_step_k),
    .i_step_n (w_step_n),
    .i_cnt_m  (r_nm),
    .i_cnt_n  (r_nn),
    .i_cnt_k  (r_nk),
    .o_m      (w_m),
    .o_n      (w_n),
    .o_k      (w_k),
    .o_m_wrap (w_m_wrap),
    .o_n_wrap (w_n_wrap),
    .o_k_wrap (w_k_wrap)
  );

`ifdef TILE_SCHED_TIMEOUT_EN
  logic [WDOG_W-1:0] r_wdog;

  // Held at zero outside RUN_MM, so every entry starts a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state != ST_RUN_MM) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout       = (r_wdog == WDOG_W'(WDOG_LIMIT - 1));
  assign bus.err_timeout = (r_state == ST_ERR);
`else
  assign w_timeout       = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_nm      <= '0;
      r_nn      <= '0;
      r_nk      <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_nm      <= bus.num_tiles_m;
        r_nn      <= bus.num_tiles_n;
        r_nk      <= bus.num_tiles_k;
        r_cfg_err <= w_zero;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_clear  = 1'b0;
    w_step_k = 1'b0;
    w_step_n = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_clear = 1'b1;
          w_next  = w_zero ? ST_DONE : ST_RUN_MM;
        end
      end
      ST_RUN_MM: begin
        if (bus.done_mat_mul) begin
          w_next = ST_STEP;
        end else if (w_timeout) begin
          w_next = ST_ERR;
        end
      end
      ST_STEP: begin
        w_step_k = 1'b1;
        w_next   = w_k_wrap ? ST_WAIT_WB : ST_RUN_MM;
      end
      ST_WAIT_WB: begin
        if (bus.wb_done) begin
          w_step_n = 1'b1;
          w_next   = (w_m_wrap && w_n_wrap) ? ST_DONE : ST_RUN_MM;
        end
      end
      ST_DONE: begin
        w_clear = 1'b1;
        w_next  = ST_IDLE;
      end
      ST_ERR:  w_next = ST_ERR;
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.start_mat_mul = (r_state == ST_RUN_MM);
  assign bus.first_k       = (r_state == ST_RUN_MM) && (w_k == '0);
  assign bus.last_k        = (r_state == ST_RUN_MM) && w_k_wrap;
  assign bus.a_loc         = tile_loc(w_m, r_nk, w_k);
  assign bus.b_loc         = tile_loc(w_k, r_nn, w_n);
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.done_all      = (r_state == ST_DONE);
  assign bus.cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_tile_scheduler.sv
// Randomized bench for tile_scheduler: a nested-loop reference model predicts every matmul request.
module tb_tile_scheduler;
  import tile_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile_scheduler_if bus();

  tile_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  int done_cnt = 0;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.start_mat_mul && !prev_req) req_cnt++;
      if (bus.done_all) done_cnt++;
    end
    prev_req = bus.start_mat_mul;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int nm, input int nn, input int nk);
    bus.num_tiles_m = 8'(nm);
    bus.num_tiles_n = 8'(nn);
    bus.num_tiles_k = 8'(nk);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Plays matmul + writeback for one layer and checks each request against the m/n/k loop model.
  task automatic drive_layer(input int nm, input int nn, input int nk, input bit strays);
    int r0, d0, w, exp_a, exp_b;
    r0 = req_cnt;
    d0 = done_cnt;
    pulse_start(nm, nn, nk);
    for (int m = 0; m < nm; m++) begin
      for (int n = 0; n < nn; n++) begin
        for (int k = 0; k < nk; k++) begin
          w = 0;
          while (!bus.start_mat_mul && w < 20) begin
            tick();
            w++;
          end
          n_checks++;
          if (bus.start_mat_mul !== 1'b1) begin
            n_fail++;
            $display("FAIL req_wait: no request for m=%0d n=%0d k=%0d (got %b, need 1)", m, n, k, bus.start_mat_mul);
            return;
          end
          exp_a = (m * nk + k) % 256;
          exp_b = (k * nn + n) % 256;
          n_checks++;
          if (bus.a_loc !== 8'(exp_a) || bus.b_loc !== 8'(exp_b) ||
              bus.first_k !== (k == 0) || bus.last_k !== (k == nk - 1)) begin
            n_fail++;
            $display("FAIL loc m=%0d n=%0d k=%0d: got a=%0d b=%0d f=%b l=%b, need a=%0d b=%0d f=%b l=%b",
                     m, n, k, bus.a_loc, bus.b_loc, bus.first_k, bus.last_k,
                     exp_a, exp_b, (k == 0), (k == nk - 1));
          end
          repeat ($urandom_range(0, 3)) begin
            if (strays && $urandom_range(0, 1) == 1) begin
              bus.start   = 1'b1;
              bus.wb_done = 1'b1;
              bus.num_tiles_m = 8'($urandom_range(0, 255));
              bus.num_tiles_n = 8'($urandom_range(0, 255));
              bus.num_tiles_k = 8'($urandom_range(0, 255));
            end
            tick();
            bus.start   = 1'b0;
            bus.wb_done = 1'b0;
          end
          bus.done_mat_mul = 1'b1;
          tick();
          bus.done_mat_mul = 1'b0;
          n_checks++;
          if (bus.start_mat_mul !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL step: got req=%b busy=%b, need req=0 busy=1", bus.start_mat_mul, bus.busy);
          end
          if (k == nk - 1) begin
            tick();
            repeat ($urandom_range(0, 2)) begin
              if (strays) bus.done_mat_mul = 1'b1;
              tick();
              bus.done_mat_mul = 1'b0;
            end
            bus.wb_done = 1'b1;
            tick();
            bus.wb_done = 1'b0;
          end
        end
      end
    end
    repeat (3) tick();
    n_checks++;
    if (req_cnt - r0 !== nm * nn * nk) begin
      n_fail++;
      $display("FAIL req_count %0dx%0dx%0d: got %0d, need %0d", nm, nn, nk, req_cnt - r0, nm * nn * nk);
    end
    n_checks++;
    if (done_cnt - d0 !== 1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL layer_end %0dx%0dx%0d: got done_cycles=%0d busy=%b, need 1 and 0",
               nm, nn, nk, done_cnt - d0, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.done_mat_mul = 1'b0; bus.wb_done = 1'b0;
    bus.num_tiles_m = 8'd3; bus.num_tiles_n = 8'd5; bus.num_tiles_k = 8'd7;
    rst_n = 1'b0;
    #23;
    n_checks++;
    if ({bus.start_mat_mul, bus.done_all, bus.busy, bus.first_k, bus.last_k, bus.cfg_err, bus.err_timeout} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, need 0000000",
               {bus.start_mat_mul, bus.done_all, bus.busy, bus.first_k, bus.last_k, bus.cfg_err, bus.err_timeout});
    end
    n_checks++;
    if (bus.a_loc !== 8'd0 || bus.b_loc !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_loc: got a=%0d b=%0d, need 0 0", bus.a_loc, bus.b_loc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || done_cnt !== 0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%0d, need 0 0", bus.busy, done_cnt);
    end
  endtask

  task automatic test_single();
    drive_layer(1, 1, 1, 1'b0);
  endtask

  task automatic test_2x2x3();
    drive_layer(2, 2, 3, 1'b0);
  endtask

  task automatic test_strays();
    drive_layer(2, 2, 3, 1'b1);
    drive_layer(3, 2, 2, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      drive_layer($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_loc_wrap();
    drive_layer(2, 3, 100, 1'b0);
  endtask

  task automatic test_cfg_err();
    int r0;
    r0 = req_cnt;
    pulse_start(2, 3, 0);
    n_checks++;
    if (bus.done_all !== 1'b1 || bus.cfg_err !== 1'b1 || bus.start_mat_mul !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_done: got done=%b err=%b req=%b, need 1 1 0", bus.done_all, bus.cfg_err, bus.start_mat_mul);
    end
    tick();
    tick();
    n_checks++;
    if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0 || req_cnt !== r0) begin
      n_fail++;
      $display("FAIL cfg_hold: got err=%b busy=%b reqs=%0d, need 1 0 %0d", bus.cfg_err, bus.busy, req_cnt, r0);
    end
    pulse_start(0, 1, 1);
    tick();
    n_checks++;
    if (bus.cfg_err !== 1'b1 || req_cnt !== r0) begin
      n_fail++;
      $display("FAIL cfg_m0: got err=%b reqs=%0d, need 1 %0d", bus.cfg_err, req_cnt, r0);
    end
    tick();
    drive_layer(1, 2, 1, 1'b0);
    n_checks++;
    if (bus.cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_clear: got %b, need 0", bus.cfg_err);
    end
  endtask

  task automatic test_reset_mid();
    int d0, w;
    pulse_start(2, 2, 2);
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 2; k++) begin
        w = 0;
        while (!bus.start_mat_mul && w < 20) begin
          tick();
          w++;
        end
        bus.done_mat_mul = 1'b1;
        tick();
        bus.done_mat_mul = 1'b0;
      end
      tick();
      if (t == 0) begin
        bus.wb_done = 1'b1;
        tick();
        bus.wb_done = 1'b0;
      end
    end
    n_checks++;
    if (bus.busy !== 1'b1 || bus.start_mat_mul !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_wb_tile1: got busy=%b req=%b, need 1 0", bus.busy, bus.start_mat_mul);
    end
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.start_mat_mul, bus.done_all, bus.busy, bus.first_k, bus.last_k, bus.cfg_err, bus.err_timeout} !== 7'b0 ||
        bus.a_loc !== 8'd0 || bus.b_loc !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: got flags=%b a=%0d b=%0d, need all 0",
               {bus.start_mat_mul, bus.done_all, bus.busy, bus.first_k, bus.last_k, bus.cfg_err, bus.err_timeout},
               bus.a_loc, bus.b_loc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.wb_done = 1'b1;
    tick();
    bus.wb_done = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (done_cnt !== d0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got done=%0d busy=%b, need %0d 0", done_cnt - d0, bus.busy, 0);
    end
  endtask

  task automatic test_timeout();
    int cyc, d0;
    d0 = done_cnt;
    pulse_start(1, 1, 1);
`ifdef TILE_SCHED_TIMEOUT_EN
    cyc = 0;
    while (bus.start_mat_mul && cyc < 400) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 255) begin
      n_fail++;
      $display("FAIL wdog_len: got %0d request cycles, need 255", cyc);
    end
    repeat (10) tick();
    n_checks++;
    if (bus.err_timeout !== 1'b1 || bus.busy !== 1'b1 || bus.start_mat_mul !== 1'b0 || done_cnt !== d0) begin
      n_fail++;
      $display("FAIL err_state: got err=%b busy=%b req=%b done=%0d, need 1 1 0 0",
               bus.err_timeout, bus.busy, bus.start_mat_mul, done_cnt - d0);
    end
`else
    cyc = 0;
    repeat (400) begin
      tick();
      if (bus.start_mat_mul) cyc++;
    end
    n_checks++;
    if (cyc !== 400 || bus.err_timeout !== 1'b0 || bus.busy !== 1'b1 || done_cnt !== d0) begin
      n_fail++;
      $display("FAIL no_wdog: got req_cycles=%0d err=%b busy=%b, need 400 0 1", cyc, bus.err_timeout, bus.busy);
    end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.err_timeout !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_reset: got err=%b busy=%b, need 0 0", bus.err_timeout, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_2x2x3();
    test_strays();
    test_random();
    test_loc_wrap();
    test_cfg_err();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
